// File: rtl/hash_core_arbiter_pkg.sv
// Shared types for the hash core arbiter: word/digest payloads, FSM encoding, field widths.
package hash_core_arbiter_pkg;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned DIGEST_W   = 256;
  localparam int unsigned BYTE_NUM_W = 3;

  typedef logic [DATA_W-1:0]   packet_input;
  typedef logic [DIGEST_W-1:0] packet_output;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    STREAM,
    WAIT_DIG,
    DONE
  } arb_state_t;

endpackage

// File: rtl/hash_core_arbiter_if.sv
// Requester-fabric and hash-core pins of the arbiter; slave = arbiter view, master = environment view.
interface hash_core_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  import hash_core_arbiter_pkg::*;

  logic        [N_REQ-1:0]                 req_valid;
  packet_input [N_REQ-1:0]                 req_data;
  logic        [N_REQ-1:0]                 req_last;
  logic        [N_REQ-1:0][BYTE_NUM_W-1:0] req_byte_num;
  logic        [N_REQ-1:0]                 req_ready;
  logic        [N_REQ-1:0]                 grant;
  packet_output                            digest;
  logic        [N_REQ-1:0]                 digest_valid;
  logic                                    err;

  logic                                    core_reset;
  packet_input                             core_in;
  logic                                    core_in_ready;
  logic                                    core_is_last;
  logic        [BYTE_NUM_W-1:0]            core_byte_num;
  logic                                    core_buffer_full;
  packet_output                            core_out;
  logic                                    core_out_ready;

  modport slave (
    input  req_valid, req_data, req_last, req_byte_num,
    input  core_buffer_full, core_out, core_out_ready,
    output req_ready, grant, digest, digest_valid, err,
    output core_reset, core_in, core_in_ready, core_is_last, core_byte_num
  );

  modport master (
    output req_valid, req_data, req_last, req_byte_num,
    output core_buffer_full, core_out, core_out_ready,
    input  req_ready, grant, digest, digest_valid, err,
    input  core_reset, core_in, core_in_ready, core_is_last, core_byte_num
  );

endinterface

// File: rtl/hash_core_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping at N.
module hash_core_arbiter_rr_pick #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     winner_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  always_comb begin
    int unsigned k;
    winner_c = '0;
    idx_c    = '0;
    any_c    = 1'b0;
    k        = 0;
    for (int unsigned i = 0; i < N; i++) begin
      // ptr < N and i < N, so a single subtraction performs the wrap
      k = 32'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any_c && req[IDX_W'(k)]) begin
        any_c                = 1'b1;
        winner_c[IDX_W'(k)]  = 1'b1;
        idx_c                = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/hash_core_arbiter.sv
// Shares one hash core between N_REQ requesters: whole-message round-robin grant,
// per-message core reset, word passthrough under back-pressure, digest return with watchdog.
module hash_core_arbiter
  import hash_core_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WAIT_MAX = 1024
) (
  input  logic               clk,
  input  logic               reset,
  hash_core_arbiter_if.slave bus
);

  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WDOG_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [N_REQ-1:0]   grant_q;
  packet_output       digest_q;
  logic [N_REQ-1:0]   digest_valid_q;
  logic               err_q;
  logic               core_reset_q;
  logic [WDOG_W-1:0]  wdog_q;

  logic [N_REQ-1:0]   pick_winner_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic               pick_any_c;
  logic               xfer_c;
  logic               wdog_hit_c;

  hash_core_arbiter_rr_pick #(.N(N_REQ)) u_rr_pick (
    .req      (bus.req_valid),
    .ptr      (rr_ptr_q),
    .winner_c (pick_winner_c),
    .idx_c    (pick_idx_c),
    .any_c    (pick_any_c)
  );

  assign wdog_hit_c = (wdog_q == WDOG_W'(WAIT_MAX - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (pick_any_c) state_d = CLR;
      CLR:      state_d = STREAM;
      STREAM:   if (xfer_c && bus.req_last[owner_q]) state_d = WAIT_DIG;
      WAIT_DIG: begin
        if (bus.core_out_ready) state_d = DONE;
        else if (wdog_hit_c)    state_d = IDLE;
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Owner's word path is combinational so a word moves in the cycle it is offered
  always_comb begin
    bus.req_ready     = '0;
    bus.core_in       = '0;
    bus.core_in_ready = 1'b0;
    bus.core_is_last  = 1'b0;
    bus.core_byte_num = '0;
    xfer_c            = 1'b0;
    if (state_q == STREAM) begin
      bus.req_ready[owner_q] = !bus.core_buffer_full;
      xfer_c                 = bus.req_valid[owner_q] && !bus.core_buffer_full;
      bus.core_in_ready      = xfer_c;
      bus.core_in            = bus.req_data[owner_q];
      bus.core_is_last       = bus.req_last[owner_q] && xfer_c;
      bus.core_byte_num      = bus.req_byte_num[owner_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      grant_q        <= '0;
      digest_q       <= '0;
      digest_valid_q <= '0;
      err_q          <= 1'b0;
      core_reset_q   <= 1'b1;
      wdog_q         <= '0;
    end else begin
      digest_valid_q <= '0;
      err_q          <= 1'b0;
      core_reset_q   <= (state_d == CLR);
      unique case (state_q)
        IDLE: begin
          if (pick_any_c) begin
            grant_q  <= pick_winner_c;
            owner_q  <= pick_idx_c;
            rr_ptr_q <= (pick_idx_c == IDX_W'(N_REQ - 1)) ? '0 : pick_idx_c + IDX_W'(1);
          end
        end
        STREAM: if (state_d == WAIT_DIG) wdog_q <= '0;
        WAIT_DIG: begin
          if (bus.core_out_ready) begin
            digest_q <= bus.core_out;
          end else if (wdog_hit_c) begin
            err_q   <= 1'b1;
            grant_q <= '0;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        DONE: begin
          digest_valid_q <= grant_q;
          grant_q        <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.grant        = grant_q;
  assign bus.digest       = digest_q;
  assign bus.digest_valid = digest_valid_q;
  assign bus.err          = err_q;
  assign bus.core_reset   = core_reset_q;

endmodule
